pwd_cand_gen: RTL and testbench

PWD_CAND_GEN -- requirements
Module: pwd_cand_gen

---
 rtl/pwd_cand_gen.sv | 86 ++++++++
 tb/tb_pwd_cand_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pwd_cand_gen.sv
// pwd_cand_gen: enumerates every string over a contiguous charset, shortest length first,
// presenting one candidate per cycle over a valid/ready handshake.
module pwd_cand_gen #(
  parameter int MIN_LEN = 1,
  parameter int MAX_LEN = 4,
  parameter logic [7:0] CHAR_FIRST = 8'h61,
  parameter logic [7:0] CHAR_LAST = 8'h7A
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         cand_ready,
  output logic         cand_valid,
  output logic [255:0] data,
  output logic [63:0]  data_length,
  output logic         busy,
  output logic         done,
  output logic [63:0]  count
);
  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;
  state_t state, nxt_state;
  logic [5:0] len, nxt_len;
  logic [255:0] chars, nxt_chars;
  logic [63:0] cnt;
  logic carry, last, xfer;

  function automatic logic [255:0] fill(input logic [5:0] n);
    fill = '0;
    for (int i = 0; i < 32; i++) if (6'(i) < n) fill[8*i+:8] = CHAR_FIRST;
  endfunction

  // Odometer: carry ripples up from the low byte; a full carry-out means every byte was at CHAR_LAST
  always_comb begin
    nxt_chars = '0;
    carry = 1'b1;
    for (int i = 0; i < MAX_LEN; i++)
      if (6'(i) < len) begin
        nxt_chars[8*i+:8] = !carry ? chars[8*i+:8] :
                            chars[8*i+:8] == CHAR_LAST ? CHAR_FIRST : chars[8*i+:8] + 8'd1;
        carry = carry && chars[8*i+:8] == CHAR_LAST;
      end
    last = carry && len == 6'(MAX_LEN);
    nxt_len = carry ? len + 6'd1 : len;
    if (carry) nxt_chars = fill(nxt_len);
  end

  assign xfer = cand_valid && cand_ready;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= nxt_state;

  always_comb begin
    nxt_state = state;
    if (state == S_GEN) nxt_state = stop ? S_IDLE : (xfer && last) ? S_DONE : S_GEN;
    else if (start) nxt_state = S_GEN;
  end

  always_comb begin
    cand_valid = state == S_GEN;
    busy = state == S_GEN;
    done = state == S_DONE;
    data = chars;
    data_length = 64'(len);
    count = cnt;
  end

  // Bytes above the current length stay zero because chars is only ever loaded from fill() or the odometer
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      chars <= '0;
      len <= '0;
      cnt <= '0;
    end else if (state != S_GEN && start) begin
      chars <= fill(6'(MIN_LEN));
      len <= 6'(MIN_LEN);
      cnt <= '0;
    end else if (state == S_GEN && xfer) begin
      cnt <= cnt + 64'd1;
      if (!stop && !last) begin
        chars <= nxt_chars;
        len <= nxt_len;
      end
    end
endmodule

// File: tb/tb_pwd_cand_gen.sv
// tb_pwd_cand_gen: checks pwd_cand_gen (MAX_LEN=2) against an index-based model of the keyspace.
module tb_pwd_cand_gen;
  logic clk = 0, reset = 1, start = 0, stop = 0, cand_ready = 0;
  logic cand_valid, busy, done;
  logic [255:0] data;
  logic [63:0] data_length, count;
  int n_cmp = 0, n_bad = 0;
  bit m_gen = 0, m_done = 0;
  int m_idx = 0, m_cnt = 0;

  always #5 clk = ~clk;

  pwd_cand_gen #(.MIN_LEN(1), .MAX_LEN(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cand_ready(cand_ready),
    .cand_valid(cand_valid), .data(data), .data_length(data_length),
    .busy(busy), .done(done), .count(count)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Candidate k (0-based): 26 one-char strings, then 676 two-char strings in lexical order
  function automatic void cand(input int k, output logic [255:0] d, output logic [63:0] l);
    d = '0;
    if (k < 26) begin
      d[7:0] = 8'(97 + k);
      l = 1;
    end else begin
      d[15:8] = 8'(97 + (k - 26) / 26);
      d[7:0] = 8'(97 + (k - 26) % 26);
      l = 2;
    end
  endfunction

  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_gen = 0; m_done = 0; m_idx = 0; m_cnt = 0;
    end else if (m_gen) begin
      if (cand_ready) m_cnt++;
      if (stop) m_gen = 0;
      else if (cand_ready) begin
        if (m_idx == 701) begin m_gen = 0; m_done = 1; end
        else m_idx++;
      end
    end else if (start) begin
      m_gen = 1; m_done = 0; m_idx = 0; m_cnt = 0;
    end

  always @(negedge clk) begin
    logic [255:0] ed;
    logic [63:0] el;
    cand(m_idx, ed, el);
    chk("valid", cand_valid, m_gen);
    chk("busy", busy, m_gen);
    chk("done", done, m_done);
    chk("count", count, m_cnt);
    if (!reset) begin
      chk("rst_data", data, 0);
      chk("rst_len", data_length, 0);
    end else if (m_gen) begin
      chk("data", data, ed);
      chk("len", data_length, el);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, cand_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_data"}, data, 0);
    chk({nm, "_len"}, data_length, 0);
    chk({nm, "_count"}, count, 0);
  endtask

  initial begin
    #2 reset = 0;
    #1 chk_zero("por");
    @(negedge clk);
    reset = 1;
    cyc(3);
    chk("idle_valid", cand_valid, 0);
    // Full sweep with cand_ready held high, start pulsed mid-run
    start = 1; cand_ready = 1;
    @(negedge clk); start = 0;
    chk("c1_data", data, 256'h61);
    chk("c1_len", data_length, 1);
    cyc(25);
    chk("c26_data", data, 256'h7a);
    @(negedge clk);
    chk("c27_data", data, 256'h6161);
    chk("c27_len", data_length, 2);
    for (int k = 28; k <= 702; k++) begin
      @(negedge clk);
      if (k == 100) start = 1;
      if (k == 101) start = 0;
    end
    chk("c702_data", data, 256'h7a7a);
    @(negedge clk);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_count", count, 702);
    // Restart from DONE, then stall on 'ab'
    start = 1;
    @(negedge clk); start = 0;
    chk("rs_data", data, 256'h61);
    chk("rs_count", count, 0);
    cyc(27);
    chk("c28_data", data, 256'h6162);
    cand_ready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_data", data, 256'h6162);
      chk("hold_len", data_length, 2);
      chk("hold_valid", cand_valid, 1);
    end
    cand_ready = 1;
    @(negedge clk);
    chk("post_hold", data, 256'h6163);
    stop = 1;
    @(negedge clk); stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_count", count, 29);
    // Stop together with the 30th transfer
    start = 1;
    @(negedge clk); start = 0;
    cyc(29);
    stop = 1;
    @(negedge clk); stop = 0;
    chk("s30_valid", cand_valid, 0);
    chk("s30_busy", busy, 0);
    chk("s30_count", count, 30);
    // Stop together with the final transfer beats exhaustion
    start = 1;
    @(negedge clk); start = 0;
    cyc(701);
    chk("f702_data", data, 256'h7a7a);
    stop = 1;
    @(negedge clk);
    chk("sf_done", done, 0);
    chk("sf_busy", busy, 0);
    chk("sf_count", count, 702);
    cyc(2); stop = 0;
    chk("idle_stop_count", count, 702);
    // Asynchronous reset mid-run
    start = 1;
    @(negedge clk); start = 0;
    cyc(10);
    #2 reset = 0;
    #1 chk_zero("arst");
    @(negedge clk);
    #2 reset = 1;
    cyc(5);
    chk("post_rst_valid", cand_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
